alu_mul_seq: RTL
================

Name: alu_mul_seq

Overview:
- Multi-cycle shift-and-add multiplier sequencer. It computes the low 8 bits of an unsigned 8x8 product using only the shared 8-bit ALU (add / andb / xor / shift).
- Sits beside the ALU in the datapath and drives its in1/in2/alu_op/sub inputs each cycle. It samples ALU out_val combinationally in the same cycle.
- The parent selects between this block and the normal decode path when driving the ALU.

Parameters:
- ITER, 8, number of multiplier bits processed (1..8); the iteration counter is 3 bits.
- EARLY_EXIT, 0, when 1, terminate after any iteration whose shifted multiplier becomes 0.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- start  input  1  request; accepted only in IDLE
- a  input  8  multiplicand, sampled on accepted start
- b  input  8  multiplier, sampled on accepted start
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse, product valid
- product  output  8  low 8 bits of a*b; holds until next accepted start
- alu_in1  output  8  to ALU in1
- alu_in2  output  8  to ALU in2
- alu_op  output  2  to ALU alu_op (00 add, 01 andb, 10 xor, 11 shift)
- alu_sub  output  1  to ALU sub (add: subtract; shift: 1 = right, 0 = left)
- alu_out  input  8  from ALU out_val (combinational)

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE, busy=0, done=0, product=0, a_reg=b_reg=acc=pp=0, cnt=0. Reset mid-operation aborts with no done pulse.
- ALU drive in IDLE/DONE: alu_op=00, alu_sub=0, alu_in1=0, alu_in2=0.
- Registers: a_reg, b_reg, acc, pp (all 8 bit), cnt (3 bit).
- IDLE: on start=1, load a_reg<=a, b_reg<=b, acc<=0, cnt<=0, clear product, go to GATE.
- GATE: op=01, in1=a_reg, in2=b_reg. The ALU gates a_reg by b_reg[0]. Capture pp<=alu_out, go to ACCUM.
- ACCUM: op=00, sub=0, in1=acc, in2=pp. Capture acc<=alu_out; carry is discarded, so the result is mod 256. Go to SHL_A.
- SHL_A: op=11, sub=0, in1=a_reg, in2=8'd1. Capture a_reg<=alu_out (logical left shift by 1). Go to SHR_B.
- SHR_B: op=11, sub=1, in1=b_reg, in2=8'd1. Capture b_reg<=alu_out (logical right shift by 1).
  - If cnt==ITER-1, or (EARLY_EXIT and alu_out==0): go to DONE.
  - Otherwise: cnt<=cnt+1, go to GATE.
- DONE: done=1 for exactly this cycle, product<=acc (visible on the DONE cycle), busy=1, go to IDLE.
- Latency, counted from the start-accept edge:
  - Full run: 4*ITER ALU cycles plus 1 DONE cycle; done is high 4*ITER+1 cycles after start (33 for ITER=8).
  - Early exit after k iterations: done at 4k+1.
- At least one iteration always runs, even if b=0.
- start while busy is ignored and not queued. start asserted in the DONE cycle is ignored; the next start is accepted in IDLE.
- start held high continuously: a new operation begins on the first IDLE cycle after DONE.
- The a_reg left shift may shift out set bits; that loss is intended (low-byte product).

Decomposition:
- alu_pkg holds:
  - typedef enum logic [1:0] alu_op_t: ALU_ADD=2'b00, ALU_ANDB=2'b01, ALU_XOR=2'b10, ALU_SHIFT=2'b11.
  - typedef enum mul_state_t: IDLE, GATE, ACCUM, SHL_A, SHR_B, DONE.
  - Constant SHIFT_RIGHT=1'b1.
- No sub-module: a single FSM with a datapath register file. The ALU is instantiated in the parent (and in the bench) and wired to the alu_* ports.

Test Plan:
- ITER=8, EARLY_EXIT=0: a=7, b=6, pulse start -> done exactly 33 cycles later, product=0x2A, busy high 33 cycles.
- a=0xFF, b=0xFF -> product=0x01. a=0x10, b=0x10 -> product=0x00 (wraps mod 256).
- EARLY_EXIT=1: a=0x55, b=0x01 -> done at cycle 5, product=0x55. b=0x00 -> done at cycle 5, product=0x00.
- a=3, b=5 started; re-assert start with a=9, b=9 at cycle 10 -> ignored, product=0x0F at cycle 33. Start held high -> second op begins the cycle after DONE.
- rst_n=0 at cycle 12 of an op -> next cycle busy=0, done=0, product=0, alu_* drive zeros. A following start with a=2, b=3 -> product=0x06.
- Every cycle, check the alu_op/alu_sub/alu_in1/alu_in2 sequence against the state table; alu_in2==1 in SHL_A and SHR_B.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the shift-and-add multiplier sequencer.
//   alu_op_t    : ALU operation encoding driven onto alu_op
//   mul_state_t : sequencer FSM states
//   SHIFT_RIGHT : alu_sub value selecting a right shift when alu_op is ALU_SHIFT
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_ANDB  = 2'b01,
    ALU_XOR   = 2'b10,
    ALU_SHIFT = 2'b11
  } alu_op_t;

  typedef enum logic [2:0] {
    IDLE,
    GATE,
    ACCUM,
    SHL_A,
    SHR_B,
    DONE
  } mul_state_t;

  localparam logic SHIFT_RIGHT = 1'b1;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Bus between the multiplier sequencer and its parent / the shared ALU.
//   start, a, b      : operation request (parent -> sequencer)
//   busy, done       : status (sequencer -> parent)
//   product          : low 8 bits of a*b (sequencer -> parent)
//   alu_in1, alu_in2 : ALU operands (sequencer -> ALU)
//   alu_op, alu_sub  : ALU operation select (sequencer -> ALU)
//   alu_out          : ALU result, combinational (ALU -> sequencer)
interface alu_mul_seq_if;
  import alu_pkg::*;

  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;
  logic [7:0] alu_in1;
  logic [7:0] alu_in2;
  alu_op_t    alu_op;
  logic       alu_sub;
  logic [7:0] alu_out;

  modport slave (
    input  start, a, b, alu_out,
    output busy, done, product, alu_in1, alu_in2, alu_op, alu_sub
  );

  modport master (
    output start, a, b, alu_out,
    input  busy, done, product, alu_in1, alu_in2, alu_op, alu_sub
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Multi-cycle shift-and-add multiplier: low byte of an unsigned 8x8 product,
// computed only through the shared 8-bit ALU (and-gate, add, shifts).
// Each iteration spends four cycles: GATE, ACCUM, SHL_A, SHR_B.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : request/status and ALU drive signals (see alu_mul_seq_if)
// Parameters:
//   ITER       : multiplier bits processed (1..8)
//   EARLY_EXIT : stop after any iteration leaving the shifted multiplier at 0
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned ITER       = 8,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_mul_seq_if.slave bus
);

  localparam logic [2:0] LAST_CNT = 3'(ITER - 1);

  mul_state_t state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] pp_q, pp_d;
  logic [7:0] prod_q, prod_d;
  logic [2:0] cnt_q, cnt_d;

  alu_op_t    alu_op;
  logic       alu_sub;
  logic [7:0] alu_in1;
  logic [7:0] alu_in2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      pp_q    <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      pp_q    <= pp_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    pp_d    = pp_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    alu_op  = ALU_ADD;
    alu_sub = 1'b0;
    alu_in1 = '0;
    alu_in2 = '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          acc_d   = '0;
          cnt_d   = '0;
          prod_d  = '0;
          state_d = GATE;
        end
      end
      GATE: begin
        // ALU and-gates in1 by in2[0]: partial product = a_reg or 0
        alu_op  = ALU_ANDB;
        alu_in1 = a_q;
        alu_in2 = b_q;
        pp_d    = bus.alu_out;
        state_d = ACCUM;
      end
      ACCUM: begin
        alu_op  = ALU_ADD;
        alu_in1 = acc_q;
        alu_in2 = pp_q;
        acc_d   = bus.alu_out;
        state_d = SHL_A;
      end
      SHL_A: begin
        alu_op  = ALU_SHIFT;
        alu_sub = ~SHIFT_RIGHT;
        alu_in1 = a_q;
        alu_in2 = 8'd1;
        a_d     = bus.alu_out;
        state_d = SHR_B;
      end
      SHR_B: begin
        alu_op  = ALU_SHIFT;
        alu_sub = SHIFT_RIGHT;
        alu_in1 = b_q;
        alu_in2 = 8'd1;
        b_d     = bus.alu_out;
        if (cnt_q == LAST_CNT || (EARLY_EXIT && bus.alu_out == '0)) begin
          // acc is already final here; loading now makes product valid in DONE
          prod_d  = acc_q;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 3'd1;
          state_d = GATE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.product = prod_q;
  assign bus.alu_op  = alu_op;
  assign bus.alu_sub = alu_sub;
  assign bus.alu_in1 = alu_in1;
  assign bus.alu_in2 = alu_in2;

endmodule
